// File: rtl/seg_scan.sv
// Multiplexed hex display scanner: time-slices NUM_DIGITS digits with an
// anti-ghost dead window per slot and frame-synchronous (tear-free) updates.
module seg_scan #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIV        = 50000,
  parameter int unsigned DEAD       = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [7:0]              data,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic                    frame_done
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VW = 4 * NUM_DIGITS;

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [VW-1:0]         r_disp_val;
  logic [NUM_DIGITS-1:0] r_disp_mask;
  logic [VW-1:0]         r_pend_val;
  logic [NUM_DIGITS-1:0] r_pend_mask;
  logic                  r_pend_v;

  logic                  w_slot_wrap;
  logic                  w_bound;
  logic [CW-1:0]         w_cnt_n;
  logic [IW-1:0]         w_idx_n;
  logic [VW-1:0]         w_disp_val_n;
  logic [NUM_DIGITS-1:0] w_disp_mask_n;
  logic [7:0]            w_data_n;
  logic [NUM_DIGITS-1:0] w_dig_n;

  // Next scan position and displayed register; outputs are decoded from these
  // so the registered outputs always match the state held alongside them.
  always_comb begin
    w_slot_wrap   = (r_cnt == CW'(DIV - 1));
    w_bound       = w_slot_wrap && (r_idx == IW'(NUM_DIGITS - 1));
    w_cnt_n       = w_slot_wrap ? '0 : r_cnt + CW'(1);
    w_idx_n       = r_idx;
    w_disp_val_n  = r_disp_val;
    w_disp_mask_n = r_disp_mask;
    w_data_n      = 8'hFF;
    w_dig_n       = '1;

    if (w_slot_wrap) begin
      w_idx_n = w_bound ? '0 : r_idx + IW'(1);
    end

    // A load on the boundary edge itself beats any older pending value.
    if (w_bound) begin
      if (load) begin
        w_disp_val_n  = value;
        w_disp_mask_n = blank_mask;
      end else if (r_pend_v) begin
        w_disp_val_n  = r_pend_val;
        w_disp_mask_n = r_pend_mask;
      end
    end

    if ((w_cnt_n >= CW'(DEAD)) && !w_disp_mask_n[w_idx_n]) begin
      w_data_n = {4'h0, w_disp_val_n[{w_idx_n, 2'b00} +: 4]};
      w_dig_n  = ~(NUM_DIGITS'(1) << w_idx_n);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_disp_val  <= '0;
      r_disp_mask <= '0;
      r_pend_val  <= '0;
      r_pend_mask <= '0;
      r_pend_v    <= 1'b0;
      data        <= 8'hFF;
      dig         <= '1;
      frame_done  <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_n;
      r_idx       <= w_idx_n;
      r_disp_val  <= w_disp_val_n;
      r_disp_mask <= w_disp_mask_n;
      data        <= w_data_n;
      dig         <= w_dig_n;
      frame_done  <= w_bound;
      if (w_bound) begin
        r_pend_v <= 1'b0;
      end else if (load) begin
        r_pend_val  <= value;
        r_pend_mask <= blank_mask;
        r_pend_v    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Randomized scoreboard bench for seg_scan: a frame-level reference model
// predicts each cycle's outputs; a monitor compares after every clock edge.
module tb_seg_scan;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int DEAD  = 1;
  localparam int FRAME = N * DIV;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [4*N-1:0] value = '0;
  logic           load = 1'b0;
  logic [N-1:0]   blank_mask = '0;
  logic [7:0]     data;
  logic [N-1:0]   dig;
  logic           frame_done;

  seg_scan #(.NUM_DIGITS(N), .DIV(DIV), .DEAD(DEAD)) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .load      (load),
    .blank_mask(blank_mask),
    .data      (data),
    .dig       (dig),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   data;
    logic [N-1:0] dig;
    logic         fd;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: pos counts cycles since reset release; shown is the
  // frame's displayed value, pending the last load seen earlier in the frame.
  int             pos = 0;
  logic [4*N-1:0] shown_val = '0;
  logic [N-1:0]   shown_mask = '0;
  logic [4*N-1:0] pend_val = '0;
  logic [N-1:0]   pend_mask = '0;
  bit             has_pend = 0;

  function automatic exp_t predict(int p, logic [4*N-1:0] v, logic [N-1:0] m, bit in_rst, int cyc);
    exp_t e;
    int   slot_cyc = p % DIV;
    int   digit    = (p / DIV) % N;
    logic [4*N-1:0] vv = v;
    e.cyc  = cyc;
    e.fd   = !in_rst && (p > 0) && (p % FRAME == 0);
    e.data = 8'hFF;
    e.dig  = '1;
    if (slot_cyc >= DEAD && !m[digit]) begin
      e.data = 8'(vv[digit*4 +: 4]);
      e.dig  = '1;
      e.dig[digit] = 1'b0;
    end
    return e;
  endfunction

  // Stimulus: drive on the falling edge, then push the outputs expected after
  // the next rising edge.
  initial begin : stim
    exp_t e;
    bit   boundary;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst        = (cyc < 3) || ($urandom_range(0, 299) == 0);
      load       = ($urandom_range(0, 5) == 0);
      value      = 16'($urandom);
      blank_mask = ($urandom_range(0, 1) == 0) ? '0 : N'($urandom);
      if (rst) begin
        pos        = 0;
        shown_val  = '0;
        shown_mask = '0;
        has_pend   = 0;
      end else begin
        boundary = ((pos + 1) % FRAME == 0);
        if (boundary) begin
          if (load) begin
            shown_val  = value;
            shown_mask = blank_mask;
          end else if (has_pend) begin
            shown_val  = pend_val;
            shown_mask = pend_mask;
          end
          has_pend = 0;
        end else if (load) begin
          pend_val  = value;
          pend_mask = blank_mask;
          has_pend  = 1;
        end
        pos++;
      end
      e = predict(pos, shown_val, shown_mask, rst, cyc);
      exp_q.push_back(e);
    end
    @(negedge clk);
    load = 1'b0;
    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor: after each rising edge, compare outputs with the oldest expectation.
  initial begin : mon
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (data !== e.data || dig !== e.dig || frame_done !== e.fd) begin
          errors++;
          $display("FAIL cycle %0d: got data=%h dig=%b frame_done=%b, required data=%h dig=%b frame_done=%b",
                   e.cyc, data, dig, frame_done, e.data, e.dig, e.fd);
        end
      end
    end
  end

endmodule
